// File: rtl/alu_pipe_hs_if.sv
// Handshake bundle for alu_pipe_hs: operand/opcode request channel and
// registered result channel, each with its own valid/ready pair.
interface alu_pipe_hs_if #(
    parameter int WIDTH = 16,
    parameter int WFUN  = 4,
    parameter int WFLAG = 4
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WFUN-1:0]  ALU_FUN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] ALU_OUT;
    logic [WIDTH-1:0] ALU_OUT_HI;
    logic             Arith_Flag;
    logic             Logic_Flag;
    logic             CMP_Flag;
    logic             Shift_Flag;
    logic [WFLAG-1:0] Flags_out;

    // Producer/consumer side: issues operations and drains results.
    modport master (
        output IN_VALID, A, B, ALU_FUN, OUT_READY,
        input  IN_READY, OUT_VALID, ALU_OUT, ALU_OUT_HI,
               Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, Flags_out
    );

    // ALU side.
    modport slave (
        input  IN_VALID, A, B, ALU_FUN, OUT_READY,
        output IN_READY, OUT_VALID, ALU_OUT, ALU_OUT_HI,
               Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, Flags_out
    );
endinterface

// File: rtl/alu_pipe_hs.sv
// WIDTH-bit ALU with valid/ready request handshake and a single registered,
// back-pressurable result slot. All ops except DIV (B!=0) complete in one
// cycle; DIV runs a restoring divider for WIDTH iterations.
module alu_pipe_hs #(
    parameter int WIDTH = 16,
    parameter int WFUN  = 4,
    parameter int WFLAG = 4
) (
    input logic          CLK,
    input logic          RST,
    alu_pipe_hs_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [WFUN-1:0] {
        OP_ADD    = 4'h0, OP_SUB    = 4'h1, OP_MUL    = 4'h2, OP_DIV    = 4'h3,
        OP_AND    = 4'h4, OP_OR     = 4'h5, OP_NAND   = 4'h6, OP_NOR    = 4'h7,
        OP_XOR    = 4'h8, OP_XNOR   = 4'h9, OP_CMP_EQ = 4'hA, OP_CMP_GT = 4'hB,
        OP_CMP_LT = 4'hC, OP_SHR    = 4'hD, OP_SHL    = 4'hE, OP_NOP    = 4'hF
    } op_e;

    typedef enum logic {S_IDLE, S_DIV} state_e;

    state_e           state_q, state_d;
    op_e              op;
    logic [WIDTH-1:0] a_in, b_in;
    logic             slot_free, accept, div_start, div_done;

    // Result slot registers
    logic             out_valid_q;
    logic [WIDTH-1:0] out_lo_q, out_hi_q;
    logic [3:0]       cls_q;          // {arith, logic, cmp, shift}
    logic [WFLAG-1:0] flags_q;        // {divz, ovf, zero, carry}

    // Divider registers
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt_q;

    assign a_in      = bus.A;
    assign b_in      = bus.B;
    assign op        = op_e'(bus.ALU_FUN);
    assign slot_free = !out_valid_q || bus.OUT_READY;
    assign bus.IN_READY = !RST && (state_q == S_IDLE) && slot_free;
    assign accept    = bus.IN_VALID && bus.IN_READY;
    assign div_start = accept && (op == OP_DIV) && (b_in != '0);

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH:0]       sum_w, diff_w, shr_w, shl_w;
    logic [2*WIDTH-1:0]   prod_w;
    logic [SW-1:0]        amt;
    logic [WIDTH-1:0]     res_lo, res_hi;
    logic [3:0]           res_cls;
    logic                 f_divz, f_ovf, f_zero, f_carry;

    assign amt    = b_in[SW-1:0];
    assign sum_w  = {1'b0, a_in} + {1'b0, b_in};
    assign diff_w = {1'b0, a_in} - {1'b0, b_in};
    assign prod_w = {{WIDTH{1'b0}}, a_in} * {{WIDTH{1'b0}}, b_in};
    // Extra low/high bit catches the last bit shifted out as CARRY.
    assign shr_w  = {a_in, 1'b0} >> amt;
    assign shl_w  = {1'b0, a_in} << amt;

    // Select the single-cycle result, class and flags for the current opcode.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        res_lo  = '0;
        res_hi  = '0;
        res_cls = 4'b0000;
        f_divz  = 1'b0;
        f_ovf   = 1'b0;
        f_carry = 1'b0;
        case (op)
            OP_ADD: begin
                res_lo  = sum_w[WIDTH-1:0];
                f_carry = sum_w[WIDTH];
                f_ovf   = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum_w[WIDTH-1] != a_in[WIDTH-1]);
                res_cls = 4'b1000;
            end
            OP_SUB: begin
                res_lo  = diff_w[WIDTH-1:0];
                f_carry = diff_w[WIDTH];
                f_ovf   = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (diff_w[WIDTH-1] != a_in[WIDTH-1]);
                res_cls = 4'b1000;
            end
            OP_MUL: begin
                res_lo  = prod_w[WIDTH-1:0];
                res_hi  = prod_w[2*WIDTH-1:WIDTH];
                f_ovf   = |prod_w[2*WIDTH-1:WIDTH];
                res_cls = 4'b1000;
            end
            OP_DIV: begin
                // Only reaches the result slot when B==0; B!=0 goes to the divider.
                res_lo  = '1;
                res_hi  = a_in;
                f_divz  = 1'b1;
                res_cls = 4'b1000;
            end
            OP_AND:    begin res_lo = a_in & b_in;    res_cls = 4'b0100; end
            OP_OR:     begin res_lo = a_in | b_in;    res_cls = 4'b0100; end
            OP_NAND:   begin res_lo = ~(a_in & b_in); res_cls = 4'b0100; end
            OP_NOR:    begin res_lo = ~(a_in | b_in); res_cls = 4'b0100; end
            OP_XOR:    begin res_lo = a_in ^ b_in;    res_cls = 4'b0100; end
            OP_XNOR:   begin res_lo = ~(a_in ^ b_in); res_cls = 4'b0100; end
            OP_CMP_EQ: begin res_lo = {{(WIDTH-1){1'b0}}, a_in == b_in}; res_cls = 4'b0010; end
            OP_CMP_GT: begin res_lo = {{(WIDTH-1){1'b0}}, a_in >  b_in}; res_cls = 4'b0010; end
            OP_CMP_LT: begin res_lo = {{(WIDTH-1){1'b0}}, a_in <  b_in}; res_cls = 4'b0010; end
            OP_SHR: begin
                res_lo  = shr_w[WIDTH:1];
                f_carry = shr_w[0];
                res_cls = 4'b0001;
            end
            OP_SHL: begin
                res_lo  = shl_w[WIDTH-1:0];
                f_carry = shl_w[WIDTH];
                res_cls = 4'b0001;
            end
            default: ;  // OP_NOP: zero result, no class
        endcase
        f_zero = (op == OP_NOP) || (res_lo == '0);
    end

    // ---------------- restoring divider step ----------------
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] div_rem_n, div_quo_n;
    logic [CW-1:0]    cnt_n;
    logic             iter_active;

    // One restoring-division iteration; holds once all WIDTH are done.
    always_comb begin
        iter_active = (cnt_q != CW'(WIDTH));
        rem_sh      = {rem_q, quo_q[WIDTH-1]};
        trial       = rem_sh - {1'b0, dvs_q};
        div_rem_n   = rem_q;
        div_quo_n   = quo_q;
        cnt_n       = cnt_q;
        if (iter_active) begin
            cnt_n = cnt_q + 1'b1;
            if (trial[WIDTH]) begin
                div_rem_n = rem_sh[WIDTH-1:0];
                div_quo_n = {quo_q[WIDTH-2:0], 1'b0};
            end else begin
                div_rem_n = trial[WIDTH-1:0];
                div_quo_n = {quo_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    assign div_done = (state_q == S_DIV) && (cnt_n == CW'(WIDTH)) && slot_free;

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: enter DIV on a non-trivial divide, leave once its result is loaded.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (div_start) state_d = S_DIV;
            S_DIV:  if (div_done)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Divider working registers.
    // NOTE: these are only meaningful while in S_DIV and are loaded on entry, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (div_start) begin
            rem_q <= '0;
            quo_q <= a_in;
            dvs_q <= b_in;
            cnt_q <= '0;
        end else if (state_q == S_DIV) begin
            rem_q <= div_rem_n;
            quo_q <= div_quo_n;
            cnt_q <= cnt_n;
        end
    end

    // Result slot: load single-cycle or divider result, clear on consume, hold otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            out_lo_q    <= '0;
            out_hi_q    <= '0;
            cls_q       <= '0;
            flags_q     <= '0;
        end else if (accept && !div_start) begin
            out_valid_q <= 1'b1;
            out_lo_q    <= res_lo;
            out_hi_q    <= res_hi;
            cls_q       <= res_cls;
            flags_q     <= {f_divz, f_ovf, f_zero, f_carry};
        end else if (div_done) begin
            out_valid_q <= 1'b1;
            out_lo_q    <= div_quo_n;
            out_hi_q    <= div_rem_n;
            cls_q       <= 4'b1000;
            flags_q     <= {1'b0, 1'b0, (div_quo_n == '0), 1'b0};
        end else if (out_valid_q && bus.OUT_READY) begin
            out_valid_q <= 1'b0;
            out_lo_q    <= '0;
            out_hi_q    <= '0;
            cls_q       <= '0;
            flags_q     <= '0;
        end
    end

    assign bus.OUT_VALID  = out_valid_q;
    assign bus.ALU_OUT    = out_lo_q;
    assign bus.ALU_OUT_HI = out_hi_q;
    assign bus.Arith_Flag = cls_q[3];
    assign bus.Logic_Flag = cls_q[2];
    assign bus.CMP_Flag   = cls_q[1];
    assign bus.Shift_Flag = cls_q[0];
    assign bus.Flags_out  = flags_q;

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Self-checking bench for alu_pipe_hs (WIDTH=16): directed scenario tasks
// plus a scoreboard fed at every accept and drained at every consume.
module tb_alu_pipe_hs;
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
                           OP_AND = 4'h4, OP_OR = 4'h5, OP_NAND = 4'h6, OP_NOR = 4'h7,
                           OP_XOR = 4'h8, OP_XNOR = 4'h9, OP_EQ = 4'hA, OP_GT = 4'hB,
                           OP_LT = 4'hC, OP_SHR = 4'hD, OP_SHL = 4'hE, OP_NOP = 4'hF;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [3:0]  cls;    // {arith, logic, cmp, shift}
        logic [3:0]  flags;  // {divz, ovf, zero, carry}
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e, mon_a;

    alu_pipe_hs_if #(.WIDTH(16), .WFUN(4), .WFLAG(4)) bus ();

    alu_pipe_hs #(.WIDTH(16), .WFUN(4), .WFLAG(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference model built from plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        int     ai, bi, sa, sb_i, s, amt;
        longint p;
        logic   divz, ovf, carry;
        ai = a; bi = b; sa = $signed(a); sb_i = $signed(b);
        divz = 0; ovf = 0; carry = 0;
        e = '0;
        amt = bi % 16;
        case (op)
            OP_ADD: begin s = ai + bi; e.lo = s[15:0]; carry = (s > 65535);
                          ovf = (sa + sb_i > 32767) || (sa + sb_i < -32768); e.cls = 4'b1000; end
            OP_SUB: begin s = ai - bi; e.lo = s[15:0]; carry = (ai < bi);
                          ovf = (sa - sb_i > 32767) || (sa - sb_i < -32768); e.cls = 4'b1000; end
            OP_MUL: begin p = longint'(ai) * longint'(bi); e.lo = p[15:0]; e.hi = p[31:16];
                          ovf = (p > 65535); e.cls = 4'b1000; end
            OP_DIV: begin
                e.cls = 4'b1000;
                if (bi == 0) begin e.lo = 16'hFFFF; e.hi = a; divz = 1; end
                else begin s = ai / bi; e.lo = s[15:0]; s = ai % bi; e.hi = s[15:0]; end
            end
            OP_AND:  begin e.lo = a & b;    e.cls = 4'b0100; end
            OP_OR:   begin e.lo = a | b;    e.cls = 4'b0100; end
            OP_NAND: begin e.lo = ~(a & b); e.cls = 4'b0100; end
            OP_NOR:  begin e.lo = ~(a | b); e.cls = 4'b0100; end
            OP_XOR:  begin e.lo = a ^ b;    e.cls = 4'b0100; end
            OP_XNOR: begin e.lo = ~(a ^ b); e.cls = 4'b0100; end
            OP_EQ:   begin e.lo = (ai == bi) ? 16'd1 : 16'd0; e.cls = 4'b0010; end
            OP_GT:   begin e.lo = (ai >  bi) ? 16'd1 : 16'd0; e.cls = 4'b0010; end
            OP_LT:   begin e.lo = (ai <  bi) ? 16'd1 : 16'd0; e.cls = 4'b0010; end
            OP_SHR:  begin s = ai >> amt; e.lo = s[15:0];
                           carry = (amt != 0) && (((ai >> (amt - 1)) & 1) != 0); e.cls = 4'b0001; end
            OP_SHL:  begin s = ai << amt; e.lo = s[15:0];
                           carry = (amt != 0) && (((ai >> (16 - amt)) & 1) != 0); e.cls = 4'b0001; end
            default: ;
        endcase
        e.flags = {divz, ovf, (op == OP_NOP) || (e.lo == 16'd0), carry};
        return e;
    endfunction

    // Scoreboard monitor, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            mon_a = {bus.ALU_OUT, bus.ALU_OUT_HI,
                     {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag}, bus.Flags_out};
            if (bus.OUT_VALID && bus.OUT_READY) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got %h expected none", mon_a);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_a !== mon_e) begin
                        errors++;
                        $display("FAIL sb_result got %h expected %h", mon_a, mon_e);
                    end
                end
            end else if (!bus.OUT_VALID) begin
                checks++;
                if (mon_a !== '0) begin
                    errors++;
                    $display("FAIL idle_outputs got %h expected 0", mon_a);
                end
            end
            if (bus.IN_VALID && bus.IN_READY)
                sb.push_back(model(bus.ALU_FUN, bus.A, bus.B));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op and hold it until accepted (bounded).
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int n;
        bus.ALU_FUN = op; bus.A = a; bus.B = b; bus.IN_VALID = 1'b1;
        n = 0;
        while (!bus.IN_READY && n < 200) begin tick(); n++; end
        if (!bus.IN_READY) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready got 0 expected 1 op %h", op);
        end
        tick();
        bus.IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.IN_READY !== 1'b0 || bus.OUT_VALID !== 1'b0 || bus.ALU_OUT !== 16'd0 || bus.Flags_out !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got rdy %b vld %b out %h fl %b expected 0 0 0000 0000",
                     bus.IN_READY, bus.OUT_VALID, bus.ALU_OUT, bus.Flags_out);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy %b vld %b expected 1 0", bus.IN_READY, bus.OUT_VALID);
        end
    endtask

    task automatic test_logic_cmp();
        bus.OUT_READY = 1'b1;
        send(OP_OR, 16'd10, 16'd5);
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.ALU_OUT !== 16'd15 || bus.Logic_Flag !== 1'b1 || bus.Flags_out !== 4'b0000) begin
            errors++;
            $display("FAIL or_10_5 got vld %b out %0d lf %b fl %b expected 1 15 1 0000",
                     bus.OUT_VALID, bus.ALU_OUT, bus.Logic_Flag, bus.Flags_out);
        end
        send(OP_GT, 16'd10, 16'd5);
        checks++;
        if (bus.ALU_OUT !== 16'd1 || bus.CMP_Flag !== 1'b1 || bus.Logic_Flag !== 1'b0) begin
            errors++;
            $display("FAIL cmp_gt got out %0d cf %b lf %b expected 1 1 0", bus.ALU_OUT, bus.CMP_Flag, bus.Logic_Flag);
        end
        send(OP_LT, 16'd10, 16'd5);
        checks++;
        if (bus.ALU_OUT !== 16'd0 || bus.Flags_out !== 4'b0010) begin
            errors++;
            $display("FAIL cmp_lt got out %0d fl %b expected 0 0010", bus.ALU_OUT, bus.Flags_out);
        end
    endtask

    task automatic test_arith();
        bus.OUT_READY = 1'b1;
        send(OP_ADD, 16'hFFFF, 16'h0001);
        checks++;
        if (bus.ALU_OUT !== 16'h0000 || bus.Flags_out !== 4'b0011) begin
            errors++;
            $display("FAIL add_carry got out %h fl %b expected 0000 0011", bus.ALU_OUT, bus.Flags_out);
        end
        send(OP_ADD, 16'h7FFF, 16'h0001);
        checks++;
        if (bus.ALU_OUT !== 16'h8000 || bus.Flags_out !== 4'b0100) begin
            errors++;
            $display("FAIL add_ovf got out %h fl %b expected 8000 0100", bus.ALU_OUT, bus.Flags_out);
        end
        send(OP_MUL, 16'h0100, 16'h0100);
        checks++;
        if (bus.ALU_OUT !== 16'h0000 || bus.ALU_OUT_HI !== 16'h0001 || bus.Flags_out !== 4'b0110 || bus.Arith_Flag !== 1'b1) begin
            errors++;
            $display("FAIL mul_hi got out %h hi %h fl %b af %b expected 0000 0001 0110 1",
                     bus.ALU_OUT, bus.ALU_OUT_HI, bus.Flags_out, bus.Arith_Flag);
        end
        send(OP_SHL, 16'h8001, 16'd1);
        checks++;
        if (bus.ALU_OUT !== 16'h0002 || bus.Flags_out !== 4'b0001 || bus.Shift_Flag !== 1'b1) begin
            errors++;
            $display("FAIL shl_carry got out %h fl %b sf %b expected 0002 0001 1", bus.ALU_OUT, bus.Flags_out, bus.Shift_Flag);
        end
        send(OP_NOP, 16'h1234, 16'h5678);
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.ALU_OUT !== 16'd0 || bus.Flags_out !== 4'b0010 ||
            {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag} !== 4'b0000) begin
            errors++;
            $display("FAIL nop got vld %b out %h fl %b expected 1 0000 0010 class 0", bus.OUT_VALID, bus.ALU_OUT, bus.Flags_out);
        end
    endtask

    task automatic test_div();
        int n;
        bus.OUT_READY = 1'b1;
        bus.ALU_FUN = OP_DIV; bus.A = 16'd100; bus.B = 16'd7; bus.IN_VALID = 1'b1;
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL div_ready_before got %b expected 1", bus.IN_READY);
        end
        tick();
        bus.IN_VALID = 1'b0;
        bus.A = 16'hDEAD; bus.B = 16'hBEEF;  // must not disturb the divide in flight
        n = 0;
        while (!bus.IN_READY && n < 100) begin tick(); n++; end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL div_busy_cycles got %0d expected 16", n);
        end
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.ALU_OUT !== 16'd14 || bus.ALU_OUT_HI !== 16'd2 || bus.Arith_Flag !== 1'b1 || bus.Flags_out !== 4'b0000) begin
            errors++;
            $display("FAIL div_100_7 got vld %b q %0d r %0d af %b fl %b expected 1 14 2 1 0000",
                     bus.OUT_VALID, bus.ALU_OUT, bus.ALU_OUT_HI, bus.Arith_Flag, bus.Flags_out);
        end
        send(OP_DIV, 16'd100, 16'd0);
        checks++;
        if (bus.ALU_OUT !== 16'hFFFF || bus.ALU_OUT_HI !== 16'd100 || bus.Flags_out !== 4'b1000) begin
            errors++;
            $display("FAIL div_by_zero got q %h r %0d fl %b expected FFFF 100 1000", bus.ALU_OUT, bus.ALU_OUT_HI, bus.Flags_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] av[12], bv[12];
        exp_t        snap, now_v;
        for (int i = 0; i < 12; i++) begin
            av[i] = 16'($urandom);
            bv[i] = 16'($urandom);
        end
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin
                bus.OUT_READY = 1'b0;
                bus.ALU_FUN = OP_ADD; bus.A = av[i]; bus.B = bv[i]; bus.IN_VALID = 1'b1;
                snap = {bus.ALU_OUT, bus.ALU_OUT_HI,
                        {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag}, bus.Flags_out};
                for (int k = 0; k < 3; k++) begin
                    tick();
                    now_v = {bus.ALU_OUT, bus.ALU_OUT_HI,
                             {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag}, bus.Flags_out};
                    checks++;
                    if (bus.IN_READY !== 1'b0 || bus.OUT_VALID !== 1'b1 || now_v !== snap) begin
                        errors++;
                        $display("FAIL stall_hold got rdy %b vld %b out %h expected 0 1 %h",
                                 bus.IN_READY, bus.OUT_VALID, now_v, snap);
                    end
                end
                bus.OUT_READY = 1'b1;
            end
            send(OP_ADD, av[i], bv[i]);
        end
    endtask

    task automatic test_random_ops();
        logic [3:0]  op;
        logic [15:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            bus.OUT_READY = ($urandom_range(0, 2) != 0);
            tick();
            bus.OUT_READY = 1'b1;
            send(op, a, b);
        end
    endtask

    task automatic test_reset_mid_div();
        int stale;
        bus.OUT_READY = 1'b1;
        send(OP_DIV, 16'd1000, 16'd3);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.ALU_OUT !== 16'd0 || bus.ALU_OUT_HI !== 16'd0 ||
            bus.Flags_out !== 4'd0 || bus.IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_div got vld %b out %h hi %h fl %b rdy %b expected 0 0 0 0 0",
                     bus.OUT_VALID, bus.ALU_OUT, bus.ALU_OUT_HI, bus.Flags_out, bus.IN_READY);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready got %b expected 1", bus.IN_READY);
        end
        stale = 0;
        repeat (25) begin
            tick();
            if (bus.OUT_VALID !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL rst_stale_result got %0d valid cycles expected 0", stale);
        end
        send(OP_SUB, 16'd3, 16'd5);
        checks++;
        if (bus.ALU_OUT !== 16'hFFFE || bus.Flags_out !== 4'b0001) begin
            errors++;
            $display("FAIL sub_borrow got out %h fl %b expected FFFE 0001", bus.ALU_OUT, bus.Flags_out);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
        bus.A = '0; bus.B = '0; bus.ALU_FUN = OP_NOP;
        test_reset();
        test_logic_cmp();
        test_arith();
        test_div();
        test_back_to_back();
        test_random_ops();
        test_reset_mid_div();
        bus.OUT_READY = 1'b1;
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
